// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains BURST_LEN words from a registered-read FIFO into a 2-entry valid/ready output buffer
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      single-cycle burst request, honoured only when idle
//   f_empty    FIFO empty flag
//   rd_en      FIFO read strobe, data returns on rd_dt one cycle later
//   rd_dt      FIFO read data
//   out_valid  output word valid
//   out_ready  downstream accept
//   out_dt     output word (head of buffer)
//   busy       burst in progress
//   burst_done one-cycle pulse when the last word of a burst is accepted
//   words_rd   words delivered in the current or last burst
module fifo_burst_reader #(
    parameter int DT_WIDTH  = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_WIDTH = $clog2(BURST_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 f_empty,
    output logic                 rd_en,
    input  logic [DT_WIDTH-1:0]  rd_dt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DT_WIDTH-1:0]  out_dt,
    output logic                 busy,
    output logic                 burst_done,
    output logic [CNT_WIDTH-1:0] words_rd
);
    localparam logic [CNT_WIDTH-1:0] LEN  = CNT_WIDTH'(BURST_LEN);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(BURST_LEN - 1);
    typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_t;
    state_t state, state_nx;
    logic [CNT_WIDTH-1:0] issued;
    logic inflight;
    logic [DT_WIDTH-1:0] mem [2];
    logic wr_ptr, rd_ptr;
    logic [1:0] buf_cnt;
    logic pop, push, done_nx;
    logic [2:0] occ;
    assign push      = inflight;
    assign pop       = out_valid & out_ready;
    // occupancy the buffer will have next cycle, counting the read already in flight
    assign occ       = 3'(buf_cnt) + 3'(inflight) - 3'(pop);
    assign out_valid = buf_cnt != 2'd0;
    assign out_dt    = mem[rd_ptr];
    assign busy      = state != IDLE;
    // completion is decided on the final handshake so burst_done and busy=0 land together
    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE:  state_nx = start ? BURST : IDLE;
            BURST: begin
                rd_en    = !f_empty && issued < LEN && occ < 3'd2;
                state_nx = (rd_en && issued == LAST) ? FLUSH : BURST;
            end
            FLUSH: begin
                done_nx  = pop && words_rd == LAST;
                state_nx = done_nx ? IDLE : FLUSH;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued     <= '0;
            words_rd   <= '0;
            inflight   <= 1'b0;
            burst_done <= 1'b0;
            buf_cnt    <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            mem[0]     <= '0;
            mem[1]     <= '0;
        end else begin
            inflight   <= rd_en;
            burst_done <= done_nx;
            if (state == IDLE && start) begin
                issued   <= '0;
                words_rd <= '0;
            end else begin
                if (rd_en) issued <= issued + 1'b1;
                if (pop)   words_rd <= words_rd + 1'b1;
            end
            if (push) begin
                mem[wr_ptr] <= rd_dt;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            buf_cnt <= buf_cnt + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed scoreboard bench for fifo_burst_reader with a registered-read FIFO model
module tb_fifo_burst_reader;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, f_empty = 1'b1, out_ready = 1'b1;
    logic rd_en, out_valid, busy, burst_done;
    logic [7:0] rd_dt = 8'h00, out_dt;
    logic [2:0] words_rd;
    int checks = 0, errors = 0;
    int cyc, rd_cnt, hs_cnt, done_cnt, rdy_mode, d0, n;
    logic [31:0] rd_log, vld_log, done_log, busy_log;
    logic prev_stall;
    logic [7:0] prev_dt;
    logic [7:0] fifo_q[$], exp_q[$];
    always #5 clk = ~clk;
    fifo_burst_reader #(.DT_WIDTH(8), .BURST_LEN(4)) dut (
        .clk(clk), .rst(rst), .start(start), .f_empty(f_empty), .rd_en(rd_en),
        .rd_dt(rd_dt), .out_valid(out_valid), .out_ready(out_ready), .out_dt(out_dt),
        .busy(busy), .burst_done(burst_done), .words_rd(words_rd)
    );
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic load(int cnt, logic [7:0] base);
        for (int i = 0; i < cnt; i++) begin
            fifo_q.push_back(base + 8'(i));
            exp_q.push_back(base + 8'(i));
        end
        f_empty = 1'b0;
    endtask
    task automatic begin_test(int mode);
        rdy_mode = mode;
        cyc = 0;
        rd_cnt = 0;
        hs_cnt = 0;
        rd_log = '0;
        vld_log = '0;
        done_log = '0;
        busy_log = '0;
        prev_stall = 1'b0;
    endtask
    // one clock cycle: entered and left at a falling edge
    task automatic step();
        logic r, hs;
        logic [7:0] w;
        out_ready = (rdy_mode == 1) ? !(cyc >= 2 && cyc <= 9) : (rdy_mode == 2) ? (cyc % 2 == 0) : 1'b1;
        #1;
        r = rd_en;
        hs = out_valid && out_ready;
        if (cyc < 32) begin
            rd_log[cyc] = r;
            vld_log[cyc] = out_valid;
            done_log[cyc] = burst_done;
            busy_log[cyc] = busy;
        end
        chk("rd_when_empty", r & f_empty, 0);
        chk("occupancy_le2", (rd_cnt - hs_cnt) <= 2, 1);
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_dt", out_dt, prev_dt);
        end
        prev_stall = out_valid && !out_ready;
        prev_dt = out_dt;
        if (hs) begin
            chk("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("out_dt", out_dt, w);
            end
        end
        if (burst_done) done_cnt++;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (r) begin
            rd_cnt++;
            if (fifo_q.size() != 0) rd_dt = fifo_q.pop_front();
        end
        f_empty = fifo_q.size() == 0;
        if (hs) hs_cnt++;
        cyc++;
        @(negedge clk);
    endtask
    task automatic wait_done(string tag, int budget);
        int k;
        k = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && k < budget) begin
            step();
            k++;
        end
        chk({tag, "_done_in_time"}, done_cnt != d0, 1);
    endtask
    initial begin
        done_cnt = 0;
        begin_test(0);
        repeat (2) @(negedge clk);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", burst_done, 0);
        chk("rst_out_dt", out_dt, 0);
        chk("rst_words_rd", words_rd, 0);
        rst = 1'b1;
        @(negedge clk);
        // full-rate burst
        begin_test(0);
        load(4, 8'h10);
        start = 1'b1;
        wait_done("t1", 30);
        chk("t1_rd_pattern", rd_log[7:0], 8'h1E);
        chk("t1_valid_pattern", vld_log[7:0], 8'h78);
        chk("t1_done_pattern", done_log[7:0], 8'h80);
        chk("t1_busy_pattern", busy_log[7:0], 8'h7E);
        chk("t1_words_rd", words_rd, 4);
        chk("t1_sb_empty", exp_q.size(), 0);
        step();
        chk("t1_done_one_cycle", burst_done, 0);
        chk("t1_words_rd_hold", words_rd, 4);
        // backpressure
        begin_test(1);
        load(4, 8'h10);
        start = 1'b1;
        wait_done("t2", 40);
        chk("t2_rd_before_release", rd_log[9:0], 10'h006);
        chk("t2_handshakes", hs_cnt, 4);
        chk("t2_words_rd", words_rd, 4);
        chk("t2_sb_empty", exp_q.size(), 0);
        // empty stall
        begin_test(0);
        load(2, 8'h20);
        start = 1'b1;
        repeat (10) step();
        chk("t3_busy_stalled", busy, 1);
        chk("t3_reads_stalled", rd_cnt, 2);
        chk("t3_words_partial", words_rd, 2);
        load(2, 8'h22);
        wait_done("t3", 30);
        chk("t3_handshakes", hs_cnt, 4);
        chk("t3_words_rd", words_rd, 4);
        chk("t3_sb_empty", exp_q.size(), 0);
        // start while busy
        begin_test(0);
        n = done_cnt;
        load(4, 8'h30);
        start = 1'b1;
        step();
        step();
        start = 1'b1;
        wait_done("t4", 30);
        repeat (10) step();
        chk("t4_single_done", done_cnt - n, 1);
        chk("t4_handshakes", hs_cnt, 4);
        chk("t4_reads", rd_cnt, 4);
        chk("t4_words_rd", words_rd, 4);
        chk("t4_idle", busy, 0);
        // reset mid-burst
        begin_test(0);
        load(4, 8'h40);
        start = 1'b1;
        n = 0;
        while (hs_cnt < 2 && n < 20) begin
            step();
            n++;
        end
        chk("t5_two_delivered", hs_cnt, 2);
        #1 rst = 1'b0;
        #1;
        chk("t5_rd_en", rd_en, 0);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", burst_done, 0);
        chk("t5_out_dt", out_dt, 0);
        chk("t5_words_rd", words_rd, 0);
        fifo_q.delete();
        exp_q.delete();
        f_empty = 1'b1;
        prev_stall = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        step();
        begin_test(0);
        load(4, 8'h50);
        start = 1'b1;
        wait_done("t5", 30);
        chk("t5_handshakes", hs_cnt, 4);
        chk("t5_words_after", words_rd, 4);
        chk("t5_sb_empty", exp_q.size(), 0);
        // alternating out_ready
        begin_test(2);
        load(4, 8'h60);
        start = 1'b1;
        wait_done("t6", 40);
        chk("t6_handshakes", hs_cnt, 4);
        chk("t6_words_rd", words_rd, 4);
        chk("t6_sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
